i2c_reg_target: RTL and testbench
=================================

Name: i2c_reg_target

Overview:
- I2C responder (target) with a small internal register file. Reached through a pointer byte, with auto-increment on successive bytes.
- It is the far end of the on-board I2C master: it decodes START/STOP, matches a 7-bit address, ACKs, accepts writes and serves reads on the PMOD SCL/SDA pair.
- Register contents are exported to fabric for LEDs/debug. SDA is driven open-drain.

Parameters:
NUM_REGS, 4, number of 8-bit registers; power of two, 2..256
PTR_W, $clog2(NUM_REGS), pointer width
SYNC_STAGES, 2, synchronizer flops on scl_i/sda_i (>=2)

Ports:
clk  in  1  system clock (100 MHz)
rst  in  1  synchronous, active-high reset
scl_i  in  1  SCL pin sample (asynchronous)
sda_i  in  1  SDA pin sample (asynchronous)
sda_oe  out  1  1 = pull SDA low; 0 = release (pad tristates)
slave_addr  in  7  own address; sampled at each START
reg_q  out  8*NUM_REGS  register file, reg k at bits [8k+7:8k]
wr_strobe  out  1  one-cycle pulse when a register is written
wr_idx  out  PTR_W  index written (valid with wr_strobe)
addr_match  out  1  high from address ACK until STOP/START
busy  out  1  high from START until STOP

Behaviour:
- Reset (sync, rst=1 at clk edge):
  - outputs: sda_oe=0, reg_q=0, wr_strobe=0, wr_idx=0, addr_match=0, busy=0.
  - internal state: pointer=0, FSM=IDLE, synchronizers preset to 1.
  - Reset mid-transfer releases SDA on the same edge.
- Input path: SYNC_STAGES flops, then one history flop. Edges are decoded on synchronized values, so pin-to-event latency is SYNC_STAGES+1 clk.
  - scl_rise/scl_fall: transitions of synced SCL.
  - START: synced SDA 1->0 while synced SCL=1.
  - STOP: synced SDA 0->1 while synced SCL=1.
- START/STOP priority:
  - START in any state -> ADDR (repeated start supported); clears bit count, sets busy, drops addr_match, sda_oe=0.
  - STOP in any state -> IDLE; busy=0, addr_match=0, sda_oe=0.
  - Pointer survives STOP.
- Bit timing: data sampled on scl_rise (MSB first); sda_oe changes only on scl_fall.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- ADDR: shift 8 bits. On the 8th scl_fall:
  - {addr[6:0]} == slave_addr: sda_oe=1, go ADDR_ACK, latch R/W.
  - Mismatch: go IGNORE with sda_oe=0.
- ADDR_ACK: on next scl_fall, addr_match=1.
  - W: sda_oe=0, go PTR.
  - R: load shifter from reg[pointer], drive MSB (sda_oe=~bit), go RDATA.
- PTR: 8 bits; pointer <= byte[PTR_W-1:0] (upper bits ignored). ACK in PTR_ACK, then WDATA.
- WDATA: 8 bits, then ACK.
  - At the 8th scl_fall (ACK start): reg[pointer] <= byte, wr_strobe=1 for one clk, wr_idx=pointer.
  - Then pointer <= pointer+1 mod NUM_REGS (wraps NUM_REGS-1 -> 0).
- RDATA: sda_oe = ~shift[7] updated each scl_fall.
  - After the 8th bit's scl_fall: release SDA, go RDATA_ACK.
- RDATA_ACK: sample master bit on scl_rise.
  - 0 (ACK): pointer+1 mod NUM_REGS; on scl_fall load the next byte and drive MSB; go RDATA.
  - 1 (NACK): go IGNORE, SDA released.
- IGNORE: sda_oe=0; waits for START/STOP only.
- Simultaneous events:
  - START/STOP detection overrides any scl edge in the same clk.
  - scl_rise and scl_fall cannot coincide.
- Never drives SCL (no clock stretching).

Decomposition:
- Package i2c_pkg: FSM state enum, I2C_ACK=1'b0 / I2C_NACK=1'b1 constants, R/W bit constants (shared with existing master/slave).
- Sub-module i2c_bus_sync: synchronizers + edge/START/STOP detector, outputs scl_rise, scl_fall, sda_s, start_det, stop_det. Reusable by the existing slave.

Test Plan:
- Write: START, 0xAA (0x55,W), 0x02, 0xA5, 0x3C, STOP.
  - Expect ACK on all 4 bytes.
  - reg2=0xA5, reg3=0x3C; two wr_strobe pulses, wr_idx 2 then 3; busy falls after STOP.
- Read with repeated start: START 0xAA, 0x02, Sr 0xAB, master ACK then NACK, STOP.
  - Master reads 0xA5 then 0x3C; sda_oe=0 after NACK.
- Address mismatch: START 0x44 (0x22,W), 0x01, 0xFF, STOP.
  - NACK on address; sda_oe never asserted; addr_match=0; reg file unchanged.
- Wrap: pointer 0x03, write 0x11,0x22,0x33.
  - reg3=0x11, reg0=0x22, reg1=0x33; final pointer=2.
  - Read without a pointer write then returns reg2.
- Reset mid-read: assert rst while sda_oe=1 during RDATA.
  - Next clk: sda_oe=0, reg_q=0, busy=0.
  - After release, a new START to 0x55 is ACKed normally.
- Pointer overflow: pointer byte 0xFE with NUM_REGS=4 gives pointer=2. Write 0x77 -> reg2=0x77.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding plus ACK and R/W bit values
// used by the master, the slave and this register target.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_IGNORE
  } i2c_state_e;

  localparam logic I2C_ACK      = 1'b0;
  localparam logic I2C_NACK     = 1'b1;
  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizers with edge, START and STOP detection on the
// synchronized values.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_s,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_p0;
  logic [SYNC_STAGES-1:0] sda_p0;
  logic                   scl_p1;
  logic                   sda_p1;
  logic                   scl_s;

  // Sync chain presets to the idle-bus level so reset never fakes an edge
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_p0 <= '1;
      sda_p0 <= '1;
      scl_p1 <= 1'b1;
      sda_p1 <= 1'b1;
    end else begin
      scl_p0 <= {scl_p0[SYNC_STAGES-2:0], scl_i};
      sda_p0 <= {sda_p0[SYNC_STAGES-2:0], sda_i};
      scl_p1 <= scl_s;
      sda_p1 <= sda_s;
    end
  end

  assign scl_s     = scl_p0[SYNC_STAGES-1];
  assign sda_s     = sda_p0[SYNC_STAGES-1];
  assign scl_rise  =  scl_s & ~scl_p1;
  assign scl_fall  = ~scl_s &  scl_p1;
  assign start_det =  scl_s & sda_p1 & ~sda_s;
  assign stop_det  =  scl_s & ~sda_p1 & sda_s;

endmodule

// File: rtl/i2c_reg_target.sv
// I2C register target: 7-bit address match, pointer byte with auto-increment,
// register writes and reads, open-drain SDA, register file exported to fabric.
module i2c_reg_target
  import i2c_pkg::*;
#(
  parameter int NUM_REGS    = 4,
  parameter int PTR_W       = $clog2(NUM_REGS),
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_oe,
  input  logic [6:0]            slave_addr,
  output logic [8*NUM_REGS-1:0] reg_q,
  output logic                  wr_strobe,
  output logic [PTR_W-1:0]      wr_idx,
  output logic                  addr_match,
  output logic                  busy
);

  logic scl_rise, scl_fall, sda_s, start_det, stop_det;

  i2c_bus_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_bus_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .sda_s     (sda_s),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  i2c_state_e       state_q, state_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] wr_idx_d;
  logic             sda_oe_d, addr_match_d, busy_d, wr_en;
  logic [7:0]       shift_q, shift_d;
  logic             rw_q, rw_d;
  logic [6:0]       own_addr_q, own_addr_d;
  logic [7:0]       regs [NUM_REGS];
  logic             byte_done;

  assign byte_done = scl_fall && (bit_cnt_q == 4'd8);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      ptr_q      <= '0;
      sda_oe     <= 1'b0;
      addr_match <= 1'b0;
      busy       <= 1'b0;
      wr_strobe  <= 1'b0;
      wr_idx     <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      ptr_q      <= ptr_d;
      sda_oe     <= sda_oe_d;
      addr_match <= addr_match_d;
      busy       <= busy_d;
      wr_strobe  <= wr_en;
      wr_idx     <= wr_idx_d;
    end
  end

  // Shifter and latched address/direction are only meaningful inside a transfer
  always_ff @(posedge clk) begin
    shift_q    <= shift_d;
    rw_q       <= rw_d;
    own_addr_q <= own_addr_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= 8'h00;
    end else if (wr_en) begin
      regs[ptr_q] <= shift_q;
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_REGS; k++) reg_q[8*k +: 8] = regs[k];
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    ptr_d        = ptr_q;
    sda_oe_d     = sda_oe;
    addr_match_d = addr_match;
    busy_d       = busy;
    wr_en        = 1'b0;
    wr_idx_d     = wr_idx;
    shift_d      = shift_q;
    rw_d         = rw_q;
    own_addr_d   = own_addr_q;

    if (start_det) begin
      state_d      = ST_ADDR;
      bit_cnt_d    = '0;
      busy_d       = 1'b1;
      addr_match_d = 1'b0;
      sda_oe_d     = 1'b0;
      own_addr_d   = slave_addr;
    end else if (stop_det) begin
      state_d      = ST_IDLE;
      busy_d       = 1'b0;
      addr_match_d = 1'b0;
      sda_oe_d     = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (byte_done) begin
            bit_cnt_d = '0;
            if (shift_q[7:1] == own_addr_q) begin
              sda_oe_d = 1'b1;
              rw_d     = shift_q[0];
              state_d  = ST_ADDR_ACK;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = ST_IGNORE;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            addr_match_d = 1'b1;
            bit_cnt_d    = '0;
            if (rw_q == I2C_RW_WRITE) begin
              sda_oe_d = 1'b0;
              state_d  = ST_PTR;
            end else begin
              shift_d  = regs[ptr_q];
              sda_oe_d = ~regs[ptr_q][7];
              state_d  = ST_RDATA;
            end
          end
        end
        ST_PTR: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (byte_done) begin
            bit_cnt_d = '0;
            ptr_d     = shift_q[PTR_W-1:0];
            sda_oe_d  = 1'b1;
            state_d   = ST_PTR_ACK;
          end
        end
        ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            state_d   = ST_WDATA;
          end
        end
        ST_WDATA: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (byte_done) begin
            bit_cnt_d = '0;
            wr_en     = 1'b1;
            wr_idx_d  = ptr_q;
            ptr_d     = ptr_q + PTR_W'(1);
            sda_oe_d  = 1'b1;
            state_d   = ST_WDATA_ACK;
          end
        end
        ST_RDATA: begin
          // Each fall advances to the next bit; the 8th fall hands SDA to the master
          if (scl_fall) begin
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = '0;
              sda_oe_d  = 1'b0;
              state_d   = ST_RDATA_ACK;
            end else begin
              shift_d   = {shift_q[6:0], 1'b0};
              sda_oe_d  = ~shift_q[6];
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        ST_RDATA_ACK: begin
          // bit_cnt=1 records that the master ACKed and the pointer already advanced
          if (scl_rise) begin
            if (sda_s == I2C_ACK) begin
              ptr_d     = ptr_q + PTR_W'(1);
              bit_cnt_d = 4'd1;
            end else begin
              state_d   = ST_IGNORE;
            end
          end else if (scl_fall && bit_cnt_q == 4'd1) begin
            bit_cnt_d = '0;
            shift_d   = regs[ptr_q];
            sda_oe_d  = ~regs[ptr_q][7];
            state_d   = ST_RDATA;
          end
        end
        ST_IDLE, ST_IGNORE: begin
          sda_oe_d = 1'b0;
        end
        default: begin
          sda_oe_d = 1'b0;
          state_d  = ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_reg_target.sv
// Bench for i2c_reg_target: bit-banged I2C master on an open-drain SDA line,
// with scoreboard queues for register writes and read-back bytes.
module tb_i2c_reg_target;
  import i2c_pkg::*;

  localparam int NUM_REGS = 4;
  localparam int PTR_W    = 2;
  localparam int Q        = 8;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  scl_m = 1'b1;
  logic                  sda_m = 1'b1;
  logic                  sda_oe, wr_strobe, addr_match, busy;
  logic [6:0]            slave_addr = 7'h55;
  logic [8*NUM_REGS-1:0] reg_q;
  logic [PTR_W-1:0]      wr_idx;
  logic                  sda_line;

  assign sda_line = sda_m & ~sda_oe;

  i2c_reg_target #(
    .NUM_REGS    (NUM_REGS),
    .PTR_W       (PTR_W),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .scl_i      (scl_m),
    .sda_i      (sda_line),
    .sda_oe     (sda_oe),
    .slave_addr (slave_addr),
    .reg_q      (reg_q),
    .wr_strobe  (wr_strobe),
    .wr_idx     (wr_idx),
    .addr_match (addr_match),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [7:0] data;
  } wr_t;

  wr_t        wr_q[$];
  wr_t        mon_e;
  logic [7:0] rd_q[$];
  logic [7:0] model[NUM_REGS];
  bit         oe_seen = 1'b0;
  int         n_checks = 0;
  int         n_pass = 0;

  // Write scoreboard: each wr_strobe must match the next queued write
  always @(negedge clk) begin
    if (sda_oe) oe_seen = 1'b1;
    if (wr_strobe) begin
      n_checks++;
      if (wr_q.size() == 0) begin
        $display("FAIL wr_unexpected: wr_idx=%0d, no write expected", wr_idx);
      end else begin
        mon_e = wr_q.pop_front();
        if (int'(wr_idx) !== mon_e.idx || reg_q[mon_e.idx*8 +: 8] !== mon_e.data)
          $display("FAIL wr_event: got idx=%0d data=%02h, expected idx=%0d data=%02h",
                   wr_idx, reg_q[mon_e.idx*8 +: 8], mon_e.idx, mon_e.data);
        else
          n_pass++;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic qwait();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    sda_m = 1'b1; qwait();
    scl_m = 1'b1; qwait();
    sda_m = 1'b0; qwait();
    scl_m = 1'b0; qwait();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; qwait();
    scl_m = 1'b1; qwait();
    sda_m = 1'b1; qwait();
  endtask

  task automatic wr_bit(input logic b);
    sda_m = b;    qwait();
    scl_m = 1'b1; qwait();
    qwait();
    scl_m = 1'b0; qwait();
  endtask

  task automatic rd_bit(output logic b);
    sda_m = 1'b1; qwait();
    scl_m = 1'b1; qwait();
    b = sda_line; qwait();
    scl_m = 1'b0; qwait();
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) wr_bit(d[i]);
    rd_bit(ack);
  endtask

  task automatic rd_byte(output logic [7:0] d, input logic ack);
    logic b;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      rd_bit(b);
      d = {d[6:0], b};
    end
    wr_bit(ack);
  endtask

  task automatic expect_wr(input int idx, input logic [7:0] d);
    wr_q.push_back('{idx: idx, data: d});
    model[idx] = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (sda_oe !== 1'b0) $display("FAIL rst_sda_oe: got %b, expected 0", sda_oe); else n_pass++;
    n_checks++; if (reg_q !== '0) $display("FAIL rst_reg_q: got %h, expected 0", reg_q); else n_pass++;
    n_checks++; if (wr_strobe !== 1'b0) $display("FAIL rst_wr_strobe: got %b, expected 0", wr_strobe); else n_pass++;
    n_checks++; if (wr_idx !== '0) $display("FAIL rst_wr_idx: got %0d, expected 0", wr_idx); else n_pass++;
    n_checks++; if (addr_match !== 1'b0) $display("FAIL rst_addr_match: got %b, expected 0", addr_match); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b, expected 0", busy); else n_pass++;
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_write();
    logic ack;
    bus_start();
    wr_byte(8'hAA, ack);
    n_checks++; if (ack !== I2C_ACK) $display("FAIL wr_addr_ack: got %b, expected 0", ack); else n_pass++;
    wr_byte(8'h02, ack);
    n_checks++; if (ack !== I2C_ACK) $display("FAIL wr_ptr_ack: got %b, expected 0", ack); else n_pass++;
    expect_wr(2, 8'hA5);
    wr_byte(8'hA5, ack);
    n_checks++; if (ack !== I2C_ACK) $display("FAIL wr_d0_ack: got %b, expected 0", ack); else n_pass++;
    expect_wr(3, 8'h3C);
    wr_byte(8'h3C, ack);
    n_checks++; if (ack !== I2C_ACK) $display("FAIL wr_d1_ack: got %b, expected 0", ack); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL wr_busy_mid: got %b, expected 1", busy); else n_pass++;
    n_checks++; if (addr_match !== 1'b1) $display("FAIL wr_match_mid: got %b, expected 1", addr_match); else n_pass++;
    bus_stop();
    repeat (4) @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL wr_busy_stop: got %b, expected 0", busy); else n_pass++;
    n_checks++; if (addr_match !== 1'b0) $display("FAIL wr_match_stop: got %b, expected 0", addr_match); else n_pass++;
    n_checks++; if (wr_q.size() != 0) $display("FAIL wr_pending: got %0d writes outstanding, expected 0", wr_q.size()); else n_pass++;
    for (int k = 0; k < NUM_REGS; k++) begin
      n_checks++;
      if (reg_q[8*k +: 8] !== model[k]) $display("FAIL wr_reg%0d: got %02h, expected %02h", k, reg_q[8*k +: 8], model[k]); else n_pass++;
    end
  endtask

  task automatic test_read_rs();
    logic       ack;
    logic [7:0] got, exp;
    bus_start();
    wr_byte(8'hAA, ack);
    n_checks++; if (ack !== I2C_ACK) $display("FAIL rd_waddr_ack: got %b, expected 0", ack); else n_pass++;
    wr_byte(8'h02, ack);
    n_checks++; if (ack !== I2C_ACK) $display("FAIL rd_ptr_ack: got %b, expected 0", ack); else n_pass++;
    bus_start();
    wr_byte(8'hAB, ack);
    n_checks++; if (ack !== I2C_ACK) $display("FAIL rd_raddr_ack: got %b, expected 0", ack); else n_pass++;
    rd_q.push_back(model[2]);
    rd_byte(got, I2C_ACK);
    exp = rd_q.pop_front();
    n_checks++; if (got !== exp) $display("FAIL rd_byte0: got %02h, expected %02h", got, exp); else n_pass++;
    rd_q.push_back(model[3]);
    rd_byte(got, I2C_NACK);
    exp = rd_q.pop_front();
    n_checks++; if (got !== exp) $display("FAIL rd_byte1: got %02h, expected %02h", got, exp); else n_pass++;
    repeat (4) @(negedge clk);
    n_checks++; if (sda_oe !== 1'b0) $display("FAIL rd_release: got %b, expected 0", sda_oe); else n_pass++;
    bus_stop();
  endtask

  task automatic test_mismatch();
    logic ack;
    oe_seen = 1'b0;
    bus_start();
    wr_byte(8'h44, ack);
    n_checks++; if (ack !== I2C_NACK) $display("FAIL mm_addr_nack: got %b, expected 1", ack); else n_pass++;
    n_checks++; if (addr_match !== 1'b0) $display("FAIL mm_match: got %b, expected 0", addr_match); else n_pass++;
    wr_byte(8'h01, ack);
    n_checks++; if (ack !== I2C_NACK) $display("FAIL mm_b1_nack: got %b, expected 1", ack); else n_pass++;
    wr_byte(8'hFF, ack);
    n_checks++; if (ack !== I2C_NACK) $display("FAIL mm_b2_nack: got %b, expected 1", ack); else n_pass++;
    bus_stop();
    repeat (4) @(negedge clk);
    n_checks++; if (oe_seen !== 1'b0) $display("FAIL mm_oe_seen: got %b, expected 0", oe_seen); else n_pass++;
    for (int k = 0; k < NUM_REGS; k++) begin
      n_checks++;
      if (reg_q[8*k +: 8] !== model[k]) $display("FAIL mm_reg%0d: got %02h, expected %02h", k, reg_q[8*k +: 8], model[k]); else n_pass++;
    end
  endtask

  task automatic test_wrap();
    logic       ack;
    logic [7:0] got, exp;
    bus_start();
    wr_byte(8'hAA, ack);
    wr_byte(8'h03, ack);
    expect_wr(3, 8'h11); wr_byte(8'h11, ack);
    expect_wr(0, 8'h22); wr_byte(8'h22, ack);
    expect_wr(1, 8'h33); wr_byte(8'h33, ack);
    n_checks++; if (ack !== I2C_ACK) $display("FAIL wrap_last_ack: got %b, expected 0", ack); else n_pass++;
    bus_stop();
    repeat (4) @(negedge clk);
    for (int k = 0; k < NUM_REGS; k++) begin
      n_checks++;
      if (reg_q[8*k +: 8] !== model[k]) $display("FAIL wrap_reg%0d: got %02h, expected %02h", k, reg_q[8*k +: 8], model[k]); else n_pass++;
    end
    bus_start();
    wr_byte(8'hAB, ack);
    n_checks++; if (ack !== I2C_ACK) $display("FAIL wrap_raddr_ack: got %b, expected 0", ack); else n_pass++;
    rd_q.push_back(model[2]);
    rd_byte(got, I2C_NACK);
    exp = rd_q.pop_front();
    n_checks++; if (got !== exp) $display("FAIL wrap_read_ptr2: got %02h, expected %02h", got, exp); else n_pass++;
    bus_stop();
  endtask

  task automatic test_overflow();
    logic ack;
    bus_start();
    wr_byte(8'hAA, ack);
    wr_byte(8'hFE, ack);
    n_checks++; if (ack !== I2C_ACK) $display("FAIL ovf_ptr_ack: got %b, expected 0", ack); else n_pass++;
    expect_wr(2, 8'h77);
    wr_byte(8'h77, ack);
    bus_stop();
    repeat (4) @(negedge clk);
    n_checks++; if (reg_q[23:16] !== 8'h77) $display("FAIL ovf_reg2: got %02h, expected 77", reg_q[23:16]); else n_pass++;
  endtask

  task automatic test_reset_mid_read();
    logic ack;
    bus_start();
    wr_byte(8'hAB, ack);
    n_checks++; if (ack !== I2C_ACK) $display("FAIL rmr_addr_ack: got %b, expected 0", ack); else n_pass++;
    // pointer is 3 and reg3=0x11, so the target is pulling SDA low for the MSB
    n_checks++; if (sda_oe !== 1'b1) $display("FAIL rmr_driving: got %b, expected 1", sda_oe); else n_pass++;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (sda_oe !== 1'b0) $display("FAIL rmr_sda_oe: got %b, expected 0", sda_oe); else n_pass++;
    n_checks++; if (reg_q !== '0) $display("FAIL rmr_reg_q: got %h, expected 0", reg_q); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rmr_busy: got %b, expected 0", busy); else n_pass++;
    for (int k = 0; k < NUM_REGS; k++) model[k] = 8'h00;
    scl_m = 1'b1;
    sda_m = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus_start();
    wr_byte(8'hAA, ack);
    n_checks++; if (ack !== I2C_ACK) $display("FAIL rmr_new_ack: got %b, expected 0", ack); else n_pass++;
    wr_byte(8'h00, ack);
    expect_wr(0, 8'h5A);
    wr_byte(8'h5A, ack);
    bus_stop();
    repeat (4) @(negedge clk);
    n_checks++; if (reg_q[7:0] !== 8'h5A) $display("FAIL rmr_reg0: got %02h, expected 5a", reg_q[7:0]); else n_pass++;
  endtask

  initial begin
    for (int k = 0; k < NUM_REGS; k++) model[k] = 8'h00;
    test_reset();
    test_write();
    test_read_rs();
    test_mismatch();
    test_wrap();
    test_overflow();
    test_reset_mid_read();
    n_checks++;
    if (wr_q.size() != 0) $display("FAIL final_pending: got %0d writes outstanding, expected 0", wr_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
